// File: rtl/branch_rs_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : branch_rs_scheduler
// Brief    : Branch reservation station with oldest-ready issue into a
//            one-deep execute register feeding a combinational branch unit,
//            plus a registered, ROB-tagged result stage.
// Revision : 1.0 - initial release
// ============================================================================
module branch_rs_scheduler #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             disp_valid,
  output logic             disp_ready,
  input  logic [TAG_W-1:0] disp_rob_tag,
  input  logic [2:0]       disp_branch_type,
  input  logic [31:0]      disp_pc,
  input  logic [31:0]      disp_imm,
  input  logic [31:0]      disp_rs1_val,
  input  logic [31:0]      disp_rs2_val,
  input  logic [TAG_W-1:0] disp_rs1_tag,
  input  logic [TAG_W-1:0] disp_rs2_tag,
  input  logic             disp_rs1_rdy,
  input  logic             disp_rs2_rdy,
  input  logic             disp_pred_taken,
  input  logic [31:0]      disp_pred_target,
  input  logic             cdb_valid,
  input  logic [TAG_W-1:0] cdb_tag,
  input  logic [31:0]      cdb_value,
  output logic [31:0]      bu_rs1_val,
  output logic [31:0]      bu_rs2_val,
  output logic [31:0]      bu_pc,
  output logic [31:0]      bu_imm,
  output logic [31:0]      bu_predicted_target,
  output logic [2:0]       bu_branch_type,
  output logic             bu_predicted_taken,
  input  logic             bu_taken,
  input  logic             bu_mispredict,
  input  logic [31:0]      bu_target,
  input  logic [31:0]      bu_correct_pc,
  output logic             res_valid,
  output logic [TAG_W-1:0] res_rob_tag,
  output logic             res_taken,
  output logic             res_mispredict,
  output logic [31:0]      res_target,
  output logic [31:0]      res_correct_pc
);

  localparam int IDX_W = $clog2(DEPTH);

  typedef struct packed {
    logic [TAG_W-1:0] rob_tag;
    logic [2:0]       btype;
    logic [31:0]      pc;
    logic [31:0]      imm;
    logic [31:0]      rs1_val;
    logic [TAG_W-1:0] rs1_tag;
    logic             rs1_rdy;
    logic [31:0]      rs2_val;
    logic [TAG_W-1:0] rs2_tag;
    logic             rs2_rdy;
    logic             pred_taken;
    logic [31:0]      pred_target;
  } entry_t;

  typedef struct packed {
    logic [TAG_W-1:0] rob_tag;
    logic [2:0]       btype;
    logic [31:0]      pc;
    logic [31:0]      imm;
    logic [31:0]      rs1_val;
    logic [31:0]      rs2_val;
    logic             pred_taken;
    logic [31:0]      pred_target;
  } ex_t;

  typedef struct packed {
    logic [TAG_W-1:0] rob_tag;
    logic             taken;
    logic             mispredict;
    logic [31:0]      target;
    logic [31:0]      correct_pc;
  } res_t;

  // Station storage. older_q[i][j] = 1 means entry i was dispatched before
  // entry j; the relation is rewritten on every dispatch, so it never wraps.
  logic [DEPTH-1:0] valid_q, valid_d;
  entry_t           ent_q   [DEPTH];
  entry_t           ent_d   [DEPTH];
  logic [DEPTH-1:0] older_q [DEPTH];
  logic [DEPTH-1:0] older_d [DEPTH];

  logic             ex_valid_q, ex_valid_d;
  ex_t              ex_q, ex_d;
  logic             res_valid_q, res_valid_d;
  res_t             res_q, res_d;

  logic             disp_fire;
  logic [IDX_W-1:0] free_idx;
  entry_t           new_ent;
  logic [DEPTH-1:0] eligible;
  logic             blocked;
  logic             issue_any;
  logic [IDX_W-1:0] issue_idx;

  assign disp_ready = ~&valid_q;
  assign disp_fire  = disp_valid & disp_ready & ~flush;

  // Lowest-index free slot and the incoming entry with dispatch-cycle wakeup.
  always_comb begin
    free_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!valid_q[i]) free_idx = IDX_W'(i);
    end
    new_ent.rob_tag     = disp_rob_tag;
    new_ent.btype       = disp_branch_type;
    new_ent.pc          = disp_pc;
    new_ent.imm         = disp_imm;
    new_ent.rs1_tag     = disp_rs1_tag;
    new_ent.rs2_tag     = disp_rs2_tag;
    new_ent.pred_taken  = disp_pred_taken;
    new_ent.pred_target = disp_pred_target;
    new_ent.rs1_rdy     = disp_rs1_rdy;
    new_ent.rs1_val     = disp_rs1_val;
    new_ent.rs2_rdy     = disp_rs2_rdy;
    new_ent.rs2_val     = disp_rs2_val;
    if (!disp_rs1_rdy && cdb_valid && (cdb_tag == disp_rs1_tag)) begin
      new_ent.rs1_rdy = 1'b1;
      new_ent.rs1_val = cdb_value;
    end
    if (!disp_rs2_rdy && cdb_valid && (cdb_tag == disp_rs2_tag)) begin
      new_ent.rs2_rdy = 1'b1;
      new_ent.rs2_val = cdb_value;
    end
  end

  // Oldest-ready select: an eligible entry wins if no other eligible entry is older.
  always_comb begin
    eligible  = '0;
    blocked   = 1'b0;
    issue_any = 1'b0;
    issue_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      eligible[i] = valid_q[i] & ent_q[i].rs1_rdy & ent_q[i].rs2_rdy;
    end
    for (int i = 0; i < DEPTH; i++) begin
      blocked = 1'b0;
      for (int j = 0; j < DEPTH; j++) begin
        if (eligible[j] && older_q[j][i]) blocked = 1'b1;
      end
      if (eligible[i] && !blocked) begin
        issue_any = 1'b1;
        issue_idx = IDX_W'(i);
      end
    end
  end

  // Station next state: wakeup, free on issue, allocate on dispatch, flush wins.
  always_comb begin
    valid_d = valid_q;
    ent_d   = ent_q;
    older_d = older_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && cdb_valid) begin
        if (!ent_q[i].rs1_rdy && (ent_q[i].rs1_tag == cdb_tag)) begin
          ent_d[i].rs1_rdy = 1'b1;
          ent_d[i].rs1_val = cdb_value;
        end
        if (!ent_q[i].rs2_rdy && (ent_q[i].rs2_tag == cdb_tag)) begin
          ent_d[i].rs2_rdy = 1'b1;
          ent_d[i].rs2_val = cdb_value;
        end
      end
    end
    if (issue_any) valid_d[issue_idx] = 1'b0;
    if (disp_fire) begin
      valid_d[free_idx] = 1'b1;
      ent_d[free_idx]   = new_ent;
      older_d[free_idx] = '0;
      for (int j = 0; j < DEPTH; j++) begin
        if (j != int'(free_idx)) older_d[j][free_idx] = 1'b1;
      end
    end
    if (flush) valid_d = '0;
  end

  // Execute register loads the winner; result register captures the branch unit.
  always_comb begin
    ex_valid_d = issue_any & ~flush;
    ex_d       = ex_q;
    if (issue_any && !flush) begin
      ex_d.rob_tag     = ent_q[issue_idx].rob_tag;
      ex_d.btype       = ent_q[issue_idx].btype;
      ex_d.pc          = ent_q[issue_idx].pc;
      ex_d.imm         = ent_q[issue_idx].imm;
      ex_d.rs1_val     = ent_q[issue_idx].rs1_val;
      ex_d.rs2_val     = ent_q[issue_idx].rs2_val;
      ex_d.pred_taken  = ent_q[issue_idx].pred_taken;
      ex_d.pred_target = ent_q[issue_idx].pred_target;
    end
    res_valid_d = ex_valid_q & ~flush;
    res_d       = res_q;
    if (ex_valid_q && !flush) begin
      res_d.rob_tag    = ex_q.rob_tag;
      res_d.taken      = bu_taken;
      res_d.mispredict = bu_mispredict;
      res_d.target     = bu_target;
      res_d.correct_pc = bu_correct_pc;
    end
  end

  // Station state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ent_q[i]   <= '0;
        older_q[i] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      for (int i = 0; i < DEPTH; i++) begin
        ent_q[i]   <= ent_d[i];
        older_q[i] <= older_d[i];
      end
    end
  end

  // Execute and result pipeline registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid_q  <= 1'b0;
      ex_q        <= '0;
      res_valid_q <= 1'b0;
      res_q       <= '0;
    end else begin
      ex_valid_q  <= ex_valid_d;
      ex_q        <= ex_d;
      res_valid_q <= res_valid_d;
      res_q       <= res_d;
    end
  end

  assign bu_rs1_val          = ex_q.rs1_val;
  assign bu_rs2_val          = ex_q.rs2_val;
  assign bu_pc               = ex_q.pc;
  assign bu_imm              = ex_q.imm;
  assign bu_predicted_target = ex_q.pred_target;
  assign bu_branch_type      = ex_q.btype;
  assign bu_predicted_taken  = ex_q.pred_taken;

  assign res_valid      = res_valid_q;
  assign res_rob_tag    = res_q.rob_tag;
  assign res_taken      = res_q.taken;
  assign res_mispredict = res_q.mispredict;
  assign res_target     = res_q.target;
  assign res_correct_pc = res_q.correct_pc;

endmodule
`default_nettype wire

// File: doc/branch_rs_scheduler.md
Name: branch_rs_scheduler

Overview:
Branch reservation station and issue scheduler for the single shared combinational branch_unit.
- Holds up to DEPTH dispatched branch/jump ops and captures missing operands from the CDB.
- Each cycle, issues the oldest fully-ready op into a one-deep execute register that drives branch_unit.
- Registers the branch_unit outcome, tagged with the ROB tag, for the ROB and the fetch redirect logic.

Parameters:
DEPTH, 4, number of station entries (power of 2, >=2)
TAG_W, 4, ROB/CDB tag width

Ports:
clk  in  1  clock
rst  in  1  reset; asynchronous, active-high
flush  in  1  synchronous squash of all held/in-flight ops
disp_valid  in  1  dispatch request
disp_ready  out  1  station not full
disp_rob_tag  in  TAG_W  ROB tag of op
disp_branch_type  in  3  branch_unit encoding (000 BEQ, 001 BNE, 100 BLT, ..., 111 JAL)
disp_pc, disp_imm  in  32  PC and sign-extended immediate
disp_rs1_val, disp_rs2_val  in  32  operand values
disp_rs1_tag, disp_rs2_tag  in  TAG_W  producer tags
disp_rs1_rdy, disp_rs2_rdy  in  1  value already valid
disp_pred_taken  in  1  predictor direction
disp_pred_target  in  32  predictor target
cdb_valid  in  1  CDB broadcast
cdb_tag  in  TAG_W  CDB tag
cdb_value  in  32  CDB data
bu_rs1_val, bu_rs2_val, bu_pc, bu_imm, bu_predicted_target  out  32  execute register to branch_unit
bu_branch_type  out  3  execute register
bu_predicted_taken  out  1  execute register
bu_taken, bu_mispredict  in  1  branch_unit result
bu_target, bu_correct_pc  in  32  branch_unit result
res_valid  out  1  registered result valid
res_rob_tag  out  TAG_W  tag of result
res_taken, res_mispredict  out  1  registered outcome
res_target, res_correct_pc  out  32  registered outcome

Behaviour:
- Reset (async, any time): all entries invalid, ex_valid=0, res_valid=0, all bu_*/res_* data outputs 0, disp_ready=1. Reset aborts in-flight ops; no result is produced.
- disp_ready = (valid entry count < DEPTH), from registered state only. A slot freed at the same edge is not visible until the next cycle.
- Dispatch: accepted when disp_valid & disp_ready and no flush. The op goes into any free entry and receives the youngest age. disp_valid while full is ignored; no state changes.
- Dispatch-cycle wakeup: if an operand is not ready and cdb_valid with cdb_tag == that operand's tag in the same cycle, it is captured as ready with cdb_value.
- Wakeup: each valid, waiting operand whose tag matches a valid CDB broadcast captures the value at the edge. There is no same-cycle CDB-to-select bypass; the entry becomes eligible the next cycle.
- Select: among valid entries with both operands ready, the oldest (dispatch order) wins.
- Issue edge: the winner's fields load the execute register, ex_valid=1, and the entry is freed. One issue per cycle. If none is eligible, ex_valid=0 and the bu_* outputs hold their last values.
- Result edge: when ex_valid=1, the next edge registers bu_* results into res_* with res_valid=1 and res_rob_tag = the execute-register tag. res_valid is a 1-cycle pulse per op; no backpressure.
- Latency: an op dispatched ready at edge E0 is issued at E1; res_valid is high after E2. Throughput is 1 op/cycle.
- The block never self-flushes on res_mispredict. The ROB asserts flush.
- flush (synchronous, priority over dispatch/issue/wakeup): at the edge, all entries invalid, ex_valid=0, res_valid=0. disp_ready=1 the following cycle.
- Age ordering survives arbitrary dispatch/issue interleavings. The age mechanism (age matrix or wrapping sequence counter) is an implementation choice but must not misorder across wrap.

Test Plan:
- Reset: assert rst mid-cycle -> disp_ready=1, res_valid=0, bu_rs1_val=0 immediately, without waiting for clk.
- Ready BEQ: dispatch tag=3, rs1=rs2=10 (ready), pc=0x1000, imm=100, pred_taken=0 at E0 -> E1: bu_pc=0x1000. After E2: res_valid=1, res_rob_tag=3, res_taken=1, res_target=0x1064, res_mispredict=1, res_correct_pc=0x1064, for exactly one cycle.
- CDB wakeup: BNE tag=5, rs1 waiting on tag 7, rs2=20 ready. Broadcast cdb_tag=7, value=10 two cycles later -> issue the edge after capture, res_taken=1 two edges after capture. A broadcast on tag 6 causes no issue.
- Age order: dispatch A (tag 1) then B (tag 2), both waiting on tag 9. One broadcast of tag 9 -> res for tag 1 then tag 2 on consecutive cycles.
- Full/flush: 4 dispatches waiting on tag 0xF -> disp_ready=0; a 5th dispatch is dropped. flush -> disp_ready=1 next cycle, and a later tag-0xF broadcast yields no res_valid.
- Same-cycle dispatch+CDB: dispatch rs1 waiting on tag 4 while cdb_tag=4, value=10 -> entry ready; res_valid two edges later with the correct value.
